// File: rtl/systolic_array_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_ctrl_pkg
// Description : Shared constants and FSM state encoding for the 9x9
//               output-stationary systolic array and its sequencer. The array,
//               the controller and the bench all take their geometry from here.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_array_ctrl_pkg;

    // Array geometry and datapath widths
    localparam int c_PEROW     = 9;
    localparam int c_PECOL     = 9;
    localparam int c_DW        = 32;
    localparam int c_BW        = 8;
    // A wavefront needs rows+cols-1 cycles to cross the whole array
    localparam int c_DRAIN_CYC = c_PEROW + c_PECOL - 1;

    // Sequencer states
    localparam int         c_ST_W     = 3;
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CLEAR = 3'd1;
    localparam logic [2:0] c_ST_FEED  = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_READ  = 3'd4;

    // Array read address format: [7:4] = row, [3:0] = col
    function automatic logic [7:0] fn_rd_addr(input logic [3:0] row, input logic [3:0] col);
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_array_ctrl_rd_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : systolic_rd_addr_gen
// Description : Row/column walker for the result readout. Steps the column on
//               every accepted result, wrapping into the next row, and flags
//               the final PE (PEROW-1, PECOL-1).
// Ports       : clk     - clock
//               rst     - asynchronous active-high reset
//               i_clr   - force row/col back to 0
//               i_adv   - advance one position (result accepted)
//               o_row   - current row
//               o_col   - current column
//               o_last  - current position is the last PE
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_rd_addr_gen #(
    parameter int PEROW = 9,
    parameter int PECOL = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_adv,
    output logic [3:0] o_row,
    output logic [3:0] o_col,
    output logic       o_last
);

    localparam logic [3:0] c_ROW_LAST = 4'(PEROW - 1);
    localparam logic [3:0] c_COL_LAST = 4'(PECOL - 1);

    logic [3:0] r_row;
    logic [3:0] r_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= 4'd0;
            r_col <= 4'd0;
        end else if (i_clr) begin
            r_row <= 4'd0;
            r_col <= 4'd0;
        end else if (i_adv) begin
            if (r_col == c_COL_LAST) begin
                r_col <= 4'd0;
                r_row <= (r_row == c_ROW_LAST) ? 4'd0 : r_row + 4'd1;
            end else begin
                r_col <= r_col + 4'd1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

endmodule
`default_nettype wire

// File: rtl/systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_ctrl
// Description : Job sequencer for the output-stationary systolic array.
//               Per accepted start: one clear cycle, host-driven feed of
//               'beats' weight/input beats, a fixed drain for the wavefront,
//               then readout of all PE results over a valid/ready stream.
// Ports       : clk, aresetn         - clock / async active-high reset
//               start, beats         - job request and feed length
//               busy, done           - job status / completion pulse
//               in_valid, in_ready   - feed stream handshake
//               in_weight, in_data   - feed beat (west weight, north vector)
//               arr_clr_n            - active-low array clear
//               arr_weight,arr_input - array edge drive
//               rd_address, rd_data  - array result read port
//               out_valid/ready/data/last - result stream
//               err_bubble           - sticky: feed beat missing in FEED
//               perf_cycles          - busy-cycle count of the last job
// Options     : SYSCTRL_PERF_EN enables the saturating busy-cycle counter;
//               otherwise perf_cycles is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_ctrl
    import systolic_array_ctrl_pkg::*;
#(
    parameter int PEROW     = c_PEROW,
    parameter int PECOL     = c_PECOL,
    parameter int DW        = c_DW,
    parameter int BW        = c_BW,
    parameter int DRAIN_CYC = c_DRAIN_CYC
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                start,
    input  logic [BW-1:0]       beats,
    output logic                busy,
    output logic                done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_weight,
    input  logic [DW*PECOL-1:0] in_data,
    output logic                arr_clr_n,
    output logic [DW-1:0]       arr_weight,
    output logic [DW*PECOL-1:0] arr_input,
    output logic [7:0]          rd_address,
    input  logic [DW-1:0]       rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic                out_last,
    output logic                err_bubble,
    output logic [31:0]         perf_cycles
);

    localparam logic [BW-1:0] c_BEAT_ONE   = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [4:0]    c_DRAIN_LAST = 5'(DRAIN_CYC - 1);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;
    logic [BW-1:0]     r_beats;
    logic [BW-1:0]     r_beat_cnt;
    logic [BW-1:0]     w_beat_cnt_inc;
    logic [4:0]        r_drain_cnt;
    logic              r_busy;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_arr_clr_n;
    logic              r_done;
    logic              r_err_bubble;

    logic              w_start_acc;
    logic              w_feed;
    logic              w_beat_fire;
    logic              w_feed_end;
    logic              w_drain_end;
    logic              w_read;
    logic              w_rd_fire;
    logic              w_rd_last;
    logic [3:0]        w_row;
    logic [3:0]        w_col;

    assign w_start_acc    = start && (r_state == c_ST_IDLE);
    assign w_feed         = (r_state == c_ST_FEED);
    assign w_beat_fire    = w_feed && in_valid;
    assign w_beat_cnt_inc = r_beat_cnt + c_BEAT_ONE;
    assign w_feed_end     = w_beat_fire && (w_beat_cnt_inc == r_beats);
    assign w_drain_end    = (r_state == c_ST_DRAIN) && (r_drain_cnt == c_DRAIN_LAST);
    assign w_read         = (r_state == c_ST_READ);
    assign w_rd_fire      = w_read && out_ready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_nxt = c_ST_CLEAR;
            // A zero-beat job has nothing to feed but still drains and reads
            c_ST_CLEAR: w_state_nxt = (r_beats == '0) ? c_ST_DRAIN : c_ST_FEED;
            c_ST_FEED:  if (w_feed_end) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_drain_end) w_state_nxt = c_ST_READ;
            c_ST_READ:  if (w_rd_fire && w_rd_last) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counters and registered status outputs. Status outputs are
    // loaded from the next state so they line up with r_state each cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge aresetn) begin
        if (aresetn) begin
            r_state      <= c_ST_IDLE;
            r_beats      <= '0;
            r_beat_cnt   <= '0;
            r_drain_cnt  <= 5'd0;
            r_busy       <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_arr_clr_n  <= 1'b0;
            r_done       <= 1'b0;
            r_err_bubble <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != c_ST_IDLE);
            r_in_ready  <= (w_state_nxt == c_ST_FEED);
            r_out_valid <= (w_state_nxt == c_ST_READ);
            r_arr_clr_n <= (w_state_nxt != c_ST_CLEAR);
            r_done      <= w_rd_fire && w_rd_last;

            if (w_start_acc) begin
                r_beats <= beats;
            end

            if (r_state == c_ST_CLEAR) begin
                r_beat_cnt <= '0;
            end else if (w_beat_fire) begin
                r_beat_cnt <= w_beat_cnt_inc;
            end

            if (r_state == c_ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 5'd1;
            end else begin
                r_drain_cnt <= 5'd0;
            end

            // The array cannot stall, so a missing beat corrupts the job
            if (w_start_acc) begin
                r_err_bubble <= 1'b0;
            end else if (w_feed && !in_valid) begin
                r_err_bubble <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Readout address walker; held at 0 outside READ
    // ------------------------------------------------------------------------
    systolic_rd_addr_gen #(
        .PEROW (PEROW),
        .PECOL (PECOL)
    ) u_rd_addr_gen (
        .clk    (clk),
        .rst    (aresetn),
        .i_clr  (!w_read),
        .i_adv  (w_rd_fire),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_last (w_rd_last)
    );

    // ------------------------------------------------------------------------
    // Output drive. Edges carry the beat only when it is valid in FEED; a
    // bubble pushes zeros because the wavefront advances regardless.
    // ------------------------------------------------------------------------
    assign arr_weight = w_beat_fire ? in_weight : '0;
    assign arr_input  = w_beat_fire ? in_data   : '0;

    assign busy       = r_busy;
    assign done       = r_done;
    assign in_ready   = r_in_ready;
    assign arr_clr_n  = r_arr_clr_n;
    assign rd_address = fn_rd_addr(w_row, w_col);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_valid ? rd_data : '0;
    assign out_last   = r_out_valid && w_rd_last;
    assign err_bubble = r_err_bubble;

`ifdef SYSCTRL_PERF_EN
    logic [31:0] r_perf;

    // Counts every non-idle cycle of the current job and then holds
    always_ff @(posedge clk or posedge aresetn) begin
        if (aresetn) begin
            r_perf <= 32'd0;
        end else if (w_start_acc) begin
            r_perf <= 32'd0;
        end else if ((r_state != c_ST_IDLE) && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array_ctrl
// Description : Directed self-checking bench for systolic_array_ctrl. The
//               array read port is modelled as a fixed function of address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array_ctrl;
    import systolic_array_ctrl_pkg::*;

`ifdef SYSCTRL_PERF_EN
    localparam logic [31:0] c_PERF_EXP = 32'd108;
`else
    localparam logic [31:0] c_PERF_EXP = 32'd0;
`endif

    logic                    clk = 1'b0;
    logic                    aresetn;
    logic                    start;
    logic [7:0]              beats;
    logic                    busy;
    logic                    done;
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             in_weight;
    logic [32*9-1:0]         in_data;
    logic                    arr_clr_n;
    logic [31:0]             arr_weight;
    logic [32*9-1:0]         arr_input;
    logic [7:0]              rd_address;
    logic [31:0]             rd_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_data;
    logic                    out_last;
    logic                    err_bubble;
    logic [31:0]             perf_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Array read model
    assign rd_data = {16'hBEEF, 8'h00, rd_address};

    systolic_array_ctrl dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .start       (start),
        .beats       (beats),
        .busy        (busy),
        .done        (done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_weight   (in_weight),
        .in_data     (in_data),
        .arr_clr_n   (arr_clr_n),
        .arr_weight  (arr_weight),
        .arr_input   (arr_input),
        .rd_address  (rd_address),
        .rd_data     (rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .err_bubble  (err_bubble),
        .perf_cycles (perf_cycles)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full job, starting and ending at a negedge with the DUT idle
    task automatic run_job(input int nbeats, input int bubble_at, input bit bp,
                           input bit start_in_drain, input int exp_feed,
                           input bit exp_err, input bit chk_perf);
        int          fc;
        int          dc;
        int          n;
        int          k;
        int          b;
        logic [3:0]  er;
        logic [3:0]  ec;
        logic [31:0] w;
        logic [32*9-1:0] d;

        start = 1'b1;
        beats = 8'(nbeats);
        @(negedge clk);
        start = 1'b0;
        chk("clear_busy", busy, 1);
        chk("clear_clr_n", arr_clr_n, 0);
        chk("clear_err", err_bubble, 0);
        chk("clear_in_ready", in_ready, 0);
        @(negedge clk);
        chk("post_clear_clr_n", arr_clr_n, 1);

        // FEED
        fc = 0;
        b  = 0;
        while (in_ready && fc < 300) begin
            w = 32'h1000_0000 + 32'(b);
            for (int l = 0; l < 9; l++) d[l*32 +: 32] = {16'h0, 8'(b), 8'(l)};
            if (fc == bubble_at) begin
                in_valid  = 1'b0;
                in_weight = 32'hDEAD_BEEF;
                in_data   = {9{32'hDEAD_BEEF}};
                #1;
                chk("bubble_weight", arr_weight, 0);
                chk("bubble_input", arr_input[31:0], 0);
            end else begin
                in_valid  = 1'b1;
                in_weight = w;
                in_data   = d;
                #1;
                chk("feed_weight", arr_weight, w);
                chk("feed_input_l0", arr_input[31:0], {16'h0, 8'(b), 8'h00});
                chk("feed_input_l8", arr_input[287:256], {16'h0, 8'(b), 8'h08});
                b++;
            end
            fc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("feed_cycles", fc, exp_feed);
        chk("drain_weight", arr_weight, 0);

        // DRAIN
        dc = 0;
        while (!out_valid && dc < 300) begin
            start = (start_in_drain && dc == 5);
            beats = 8'd3;
            dc++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("drain_cycles", dc, 17);

        // READ
        er = 4'd0;
        ec = 4'd0;
        n  = 0;
        k  = 0;
        while (out_valid && k < 1000) begin
            out_ready = bp ? (k % 2 == 0) : 1'b1;
            #1;
            chk("rd_address", rd_address, {er, ec});
            chk("out_data", out_data, {16'hBEEF, 8'h00, er, ec});
            chk("out_last", out_last, (er == 4'd8 && ec == 4'd8));
            if (out_ready) begin
                n++;
                if (ec == 4'd8) begin
                    ec = 4'd0;
                    er = er + 4'd1;
                end else begin
                    ec = ec + 4'd1;
                end
            end
            k++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("result_count", n, 81);
        chk("done_pulse", done, 1);
        chk("idle_busy", busy, 0);
        chk("err_bubble", err_bubble, exp_err);
        if (chk_perf) chk("perf_cycles", perf_cycles, c_PERF_EXP);
        @(negedge clk);
        chk("done_single", done, 0);
    endtask

    initial begin
        int g;
        aresetn   = 1'b1;
        start     = 1'b0;
        beats     = 8'd0;
        in_valid  = 1'b0;
        in_weight = 32'd0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset then idle
        repeat (3) @(negedge clk);
        chk("rst_clr_n", arr_clr_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_bubble, 0);
        chk("rst_perf", perf_cycles, 0);
        aresetn = 1'b0;
        @(negedge clk);
        chk("idle_clr_n", arr_clr_n, 1);
        chk("idle_busy0", busy, 0);

        // Nominal job
        run_job(9, -1, 1'b0, 1'b0, 9, 1'b0, 1'b1);

        // Bubble in the third FEED cycle; error stays up while idle
        run_job(4, 2, 1'b0, 1'b0, 5, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("err_sticky", err_bubble, 1);

        // Back-pressure in READ (next start clears err_bubble)
        run_job(9, -1, 1'b1, 1'b0, 9, 1'b0, 1'b0);

        // Zero beats, with a start pulse during DRAIN
        run_job(0, -1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("drain_start_ignored", busy, 0);

        // Reset in the middle of READ
        in_valid = 1'b1;
        start    = 1'b1;
        beats    = 8'd1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (!out_valid && g < 100) begin
            g++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("reach_read", out_valid, 1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        chk("mid_read_addr", rd_address, 8'h03);
        #2;
        aresetn = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_clr_n", arr_clr_n, 0);
        chk("async_addr", rd_address, 0);
        @(negedge clk);
        aresetn = 1'b0;
        @(negedge clk);
        chk("post_rst_clr_n", arr_clr_n, 1);
        chk("post_rst_busy", busy, 0);

        // Recovery job
        run_job(2, -1, 1'b0, 1'b0, 2, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
Sequencer for the 9x9 output-stationary systolic array. It sequences one job per start pulse:
- clears the array accumulators;
- streams a host-supplied number of weight/input beats into the west and north edges;
- waits for the wavefront to drain;
- reads all 81 PE results out over a valid/ready stream.

It sits between the host DMA/stream logic and the array's edge and read ports.

Parameters:
PEROW, 9, PE rows in the array
PECOL, 9, PE columns in the array
DW, 32, data width per PE operand/result
BW, 8, width of the beat-count field
DRAIN_CYC, PEROW+PECOL-1 (17), cycles waited after the last beat before readout

Ports:
clk  in  1  clock; all logic on rising edge
aresetn  in  1  asynchronous reset, active-high; port name kept to match the codebase
start  in  1  one-cycle job request; honoured only in IDLE
beats  in  BW  number of feed beats, sampled on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the job completes
in_valid  in  1  feed beat valid
in_ready  out  1  high only in FEED
in_weight  in  DW  west-edge weight for the beat
in_data  in  DW*PECOL  north-edge row vector for the beat
arr_clr_n  out  1  active-low clear to the array's reset input
arr_weight  out  DW  to array weight_data
arr_input  out  DW*PECOL  to array input_data
rd_address  out  8  to array; [7:4]=row, [3:0]=col
rd_data  in  DW  from array (combinational read)
out_valid  out  1  result valid
out_ready  in  1  result accepted
out_data  out  DW  result = rd_data
out_last  out  1  high with the result at row 8, col 8
err_bubble  out  1  sticky flag: in_valid was low during FEED; cleared on the next accepted start
perf_cycles  out  32  see Optional Feature

Behaviour:
- Reset values:
  - FSM in IDLE.
  - arr_clr_n=0 (array held clear while reset is asserted).
  - All other outputs 0; all counters 0.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> READ -> IDLE.
- IDLE:
  - arr_clr_n=1; array edges driven 0.
  - start=1: latch beats, clear err_bubble, go to CLEAR.
- CLEAR:
  - Exactly 1 cycle with arr_clr_n=0.
  - Next state is FEED, or DRAIN if the latched beats==0.
- FEED:
  - in_ready=1.
  - Each cycle, arr_weight and arr_input are driven combinationally from in_weight and in_data when in_valid=1; otherwise both are 0.
  - The array has no stall, so a bubble cycle still advances the wavefront.
  - The beat counter increments only on in_valid&&in_ready.
  - Any cycle with in_valid=0 sets err_bubble.
  - When the counter reaches the latched beats: go to DRAIN.
- DRAIN:
  - Edges driven 0; counter runs DRAIN_CYC cycles.
  - Then go to READ with row=0, col=0.
- READ:
  - rd_address = {row[3:0], col[3:0]}.
  - out_valid=1; out_data=rd_data (zero latency).
  - On out_valid&&out_ready: col increments; at col=PECOL-1, col wraps to 0 and row increments.
  - out_last=1 when row=PEROW-1 and col=PECOL-1.
  - The handshake on the last result pulses done and returns to IDLE.
  - While out_ready=0, address and data are held stable.
- start while busy: ignored, with no effect on the job.
- Asynchronous reset mid-job: FSM returns to IDLE immediately, array clear asserted, and the partial job is discarded.
- Counters use BW bits for beats and 5 bits for drain; row/col are 4 bits. No other arithmetic is performed.

Optional Feature:
SYSCTRL_PERF_EN:
- When defined: a 32-bit counter clears on the accepted start, increments every busy cycle, and saturates at all-ones. perf_cycles holds the final value until the next start.
- When undefined: perf_cycles is constant 0 and no counter is synthesised.

Decomposition:
- Shared package: the FSM state encoding (IDLE, CLEAR, FEED, DRAIN, READ) and the PEROW/PECOL/DW/DRAIN_CYC constants, so that array, controller and bench agree.
- One sub-module is natural: systolic_rd_addr_gen. It is the row/col counter with advance/last outputs used in READ.

Test Plan:
- Reset then idle: aresetn=1 for 3 cycles -> arr_clr_n=0, busy=0, out_valid=0. After release -> arr_clr_n=1.
- Nominal job, beats=9, contiguous in_valid, out_ready=1:
  - CLEAR lasts 1 cycle and FEED 9 cycles; DRAIN is exactly 17 cycles.
  - Then 81 results at rd_address 0x00..0x08, 0x10..0x88; out_last on 0x88; done pulses 1 cycle after that handshake; err_bubble=0.
- Bubble: beats=4, in_valid low for 1 cycle in FEED:
  - The bubble cycle drives zeros and does not count; FEED lasts 5 cycles.
  - err_bubble=1 until the next start.
- Back-pressure: out_ready toggled 1/0 every cycle in READ -> address advances only on handshake; 81 results in order with none repeated or skipped.
- Edge cases:
  - beats=0: FSM goes CLEAR->DRAIN directly.
  - start asserted during DRAIN: ignored.
  - aresetn pulsed mid-READ: FSM returns to IDLE and busy=0 immediately.
- With SYSCTRL_PERF_EN and the nominal job with out_ready=1: perf_cycles=1+9+17+81=108.
